// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: carries instr/ctrl/data/err across one stage with
// valid/ready handshake, flush-to-NOP, optional skid entry, protocol checker and stall counter.
module pipe_stage_reg #(
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800,
  parameter int                 CTRL_W    = 4,
  parameter int                 DATA_W    = 64,
  parameter int                 SKID      = 1,
  parameter int                 CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic               err,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_err,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int PAY_W = INSTR_W + CTRL_W + DATA_W + 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t state_q, state_d;

  logic               vld_p1, skid_vld_p1;
  logic               in_fire, out_fire;
  logic               ld_main_in, ld_main_skid, ld_skid;
  logic [INSTR_W-1:0] instr_p1, skid_instr_p1;
  logic [CTRL_W-1:0]  ctrl_p1, skid_ctrl_p1;
  logic [DATA_W-1:0]  data_p1, skid_data_p1;
  logic               err_p1, skid_err_p1;
  logic [PAY_W-1:0]   pay_p0, pay_hold;
  logic               stall_hold;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  assign vld_p1      = (state_q != ST_EMPTY);
  assign skid_vld_p1 = (state_q == ST_SKID);

  // With a skid entry, ready depends only on local state so out_ready never reaches in_ready.
  if (SKID != 0) begin : g_skid_rdy
    assign in_ready = ~skid_vld_p1 & ~rst;
  end else begin : g_flat_rdy
    assign in_ready = (~vld_p1 | out_ready) & ~rst;
  end

  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = vld_p1 & out_ready;

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d    = ST_FULL;
          ld_main_in = 1'b1;
        end
      end
      ST_FULL: begin
        if (in_fire && out_fire) begin
          ld_main_in = 1'b1;
        end else if (in_fire) begin
          state_d = ST_SKID;
          ld_skid = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (out_fire) begin
          state_d      = ST_FULL;
          ld_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d      = ST_EMPTY;
      ld_main_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Stage p1: main register (out_data deliberately survives flush)
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_p1 <= NOP_INSTR;
      ctrl_p1  <= '0;
      data_p1  <= '0;
      err_p1   <= 1'b0;
    end else if (flush) begin
      instr_p1 <= NOP_INSTR;
      ctrl_p1  <= '0;
      err_p1   <= 1'b0;
    end else if (ld_main_in) begin
      instr_p1 <= in_instr;
      ctrl_p1  <= in_ctrl;
      data_p1  <= in_data;
      err_p1   <= in_err;
    end else if (ld_main_skid) begin
      instr_p1 <= skid_instr_p1;
      ctrl_p1  <= skid_ctrl_p1;
      data_p1  <= skid_data_p1;
      err_p1   <= skid_err_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_skid) begin
      skid_instr_p1 <= in_instr;
      skid_ctrl_p1  <= in_ctrl;
      skid_data_p1  <= in_data;
      skid_err_p1   <= in_err;
    end
  end

  assign out_valid = vld_p1;
  assign out_instr = vld_p1 ? instr_p1 : NOP_INSTR;
  assign out_ctrl  = ctrl_p1 & {CTRL_W{vld_p1}};
  assign out_data  = data_p1;
  assign out_err   = err_p1 & vld_p1;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (vld_p1 && !out_ready) cnt_q <= sat_inc(cnt_q);
  end

  assign stall_cnt = cnt_q;

  // A beat offered during flush is discarded, so upstream need not hold it afterwards.
  assign pay_p0 = {in_instr, in_ctrl, in_data, in_err};

  always_ff @(posedge clk) begin
    pay_hold <= pay_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_hold <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      stall_hold <= in_valid & ~in_ready & ~flush;
      if (stall_hold && !flush && (!in_valid || (pay_p0 != pay_hold))) err_q <= 1'b1;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1 with CNT_W=8, plus a CNT_W=2 copy on the same inputs.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_err, out_ready;
  logic [15:0] in_instr;
  logic [3:0]  in_ctrl;
  logic [63:0] in_data;

  logic        err, in_ready, out_valid, out_err;
  logic [15:0] out_instr;
  logic [3:0]  out_ctrl;
  logic [63:0] out_data;
  logic [7:0]  stall_cnt;

  logic        err2, in_ready2, out_valid2, out_err2;
  logic [15:0] out_instr2;
  logic [3:0]  out_ctrl2;
  logic [63:0] out_data2;
  logic [1:0]  stall_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.INSTR_W(16), .NOP_INSTR(16'h0800), .CTRL_W(4), .DATA_W(64),
                   .SKID(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .err(err), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_ctrl(in_ctrl),
    .in_data(in_data), .in_err(in_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_ctrl(out_ctrl),
    .out_data(out_data), .out_err(out_err), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.INSTR_W(16), .NOP_INSTR(16'h0800), .CTRL_W(4), .DATA_W(64),
                   .SKID(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .err(err2), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_instr(in_instr), .in_ctrl(in_ctrl),
    .in_data(in_data), .in_err(in_err),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2), .out_ctrl(out_ctrl2),
    .out_data(out_data2), .out_err(out_err2), .stall_cnt(stall_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] i, input logic [3:0] c,
                       input logic [63:0] d, input logic e);
    in_valid = v;
    in_instr = i;
    in_ctrl  = c;
    in_data  = d;
    in_err   = e;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_instr"}, 64'(out_instr), 64'h0800);
    chk({tag, "_out_ctrl"},  64'(out_ctrl),  64'd0);
    chk({tag, "_out_data"},  out_data,       64'd0);
    chk({tag, "_out_err"},   64'(out_err),   64'd0);
    chk({tag, "_err"},       64'(err),       64'd0);
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 64'h0, 1'b0);
    tick(); tick();
    chk_reset_state("reset");
    rst = 1'b0;
    tick();
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Streaming with out_ready high: one beat per cycle, one cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h1001 + 16'(i), 4'hF, 64'(100 + i), 1'b0);
      tick();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_instr", 64'(out_instr), 64'(16'h1001 + 16'(i)));
      chk("stream_data",  out_data, 64'(100 + i));
      chk("stream_ctrl",  64'(out_ctrl), 64'hF);
    end
    drive(1'b0, 16'h0, 4'h0, 64'h0, 1'b0);
    tick();
    chk("stream_drain_valid", 64'(out_valid), 64'd0);
    chk("stream_drain_instr", 64'(out_instr), 64'h0800);
    chk("stream_stall", 64'(stall_cnt), 64'd0);
    chk("stream_err", 64'(err), 64'd0);

    // Backpressure: FULL then SKID, third beat held off
    out_ready = 1'b0;
    drive(1'b1, 16'h2001, 4'h1, 64'h21, 1'b0);
    tick();
    chk("bp_first_instr", 64'(out_instr), 64'h2001);
    chk("bp_first_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 16'h2002, 4'h2, 64'h22, 1'b0);
    tick();
    chk("bp_skid_ready", 64'(in_ready), 64'd0);
    chk("bp_skid_instr", 64'(out_instr), 64'h2001);
    drive(1'b1, 16'h2003, 4'h3, 64'h23, 1'b0);
    tick();
    chk("bp_hold_instr", 64'(out_instr), 64'h2001);
    tick();
    chk("bp_stall3", 64'(stall_cnt), 64'd3);
    out_ready = 1'b1;
    tick();
    chk("bp_beat2", 64'(out_instr), 64'h2002);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    tick();
    chk("bp_beat3", 64'(out_instr), 64'h2003);
    chk("bp_beat3_data", out_data, 64'h23);
    drive(1'b0, 16'h0, 4'h0, 64'h0, 1'b0);
    tick();
    chk("bp_drain_valid", 64'(out_valid), 64'd0);
    chk("bp_stall_total", 64'(stall_cnt), 64'd3);
    chk("bp_err", 64'(err), 64'd0);

    // Flush with both entries held and a beat on the input
    out_ready = 1'b0;
    drive(1'b1, 16'h3001, 4'hF, 64'hD0D0, 1'b0);
    tick();
    drive(1'b1, 16'h3002, 4'hF, 64'hD1D1, 1'b0);
    tick();
    drive(1'b1, 16'h3003, 4'hF, 64'hD2D2, 1'b0);
    flush = 1'b1;
    tick();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_instr", 64'(out_instr), 64'h0800);
    chk("flush_ctrl",  64'(out_ctrl),  64'd0);
    chk("flush_ready", 64'(in_ready),  64'd1);
    chk("flush_data_kept", out_data, 64'hD0D0);
    chk("flush_stall", 64'(stall_cnt), 64'd5);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 16'h0, 4'h0, 64'h0, 1'b0);
    tick();
    chk("flush_nothing_out", 64'(out_valid), 64'd0);
    chk("flush_err", 64'(err), 64'd0);

    // Gated control and error on a held then flushed beat
    out_ready = 1'b0;
    drive(1'b1, 16'h4001, 4'hF, 64'h44, 1'b1);
    tick();
    chk("gate_ctrl_valid", 64'(out_ctrl), 64'hF);
    chk("gate_err_valid",  64'(out_err),  64'd1);
    drive(1'b0, 16'h0, 4'h0, 64'h0, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("gate_valid_off", 64'(out_valid), 64'd0);
    chk("gate_ctrl_off",  64'(out_ctrl),  64'd0);
    chk("gate_err_off",   64'(out_err),   64'd0);
    chk("gate_stall",     64'(stall_cnt), 64'd7);

    // Protocol violation: stalled beat changes payload
    drive(1'b1, 16'h5001, 4'h1, 64'h51, 1'b0);
    tick();
    drive(1'b1, 16'h5002, 4'h2, 64'h52, 1'b0);
    tick();
    drive(1'b1, 16'h5003, 4'h3, 64'h55, 1'b0);
    tick();
    chk("viol_pre_err", 64'(err), 64'd0);
    in_data = 64'h56;
    tick();
    chk("viol_err_set", 64'(err), 64'd1);
    tick();
    chk("viol_err_sticky", 64'(err), 64'd1);
    chk("sat_mid_cnt2", 64'(stall_cnt2), 64'd3);

    // Reset while both entries are held
    rst = 1'b1;
    tick();
    chk_reset_state("rst_mid_skid");
    chk("rst_cnt2", 64'(stall_cnt2), 64'd0);
    rst = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 64'h0, 1'b0);
    tick();
    chk("rst_release_ready", 64'(in_ready), 64'd1);

    // Same payload change while flush is high is exempt
    drive(1'b1, 16'h6001, 4'h1, 64'h61, 1'b0);
    tick();
    drive(1'b1, 16'h6002, 4'h2, 64'h62, 1'b0);
    tick();
    drive(1'b1, 16'h6003, 4'h3, 64'h66, 1'b0);
    tick();
    in_data = 64'h67;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("exempt_err", 64'(err), 64'd0);
    chk("exempt_valid", 64'(out_valid), 64'd0);
    drive(1'b0, 16'h0, 4'h0, 64'h0, 1'b0);
    tick();
    chk("exempt_err_after", 64'(err), 64'd0);
    chk("exempt_stall", 64'(stall_cnt), 64'd3);

    // Saturation of the 2-bit counter over 5 stalled cycles
    drive(1'b1, 16'h7001, 4'h0, 64'h71, 1'b0);
    tick();
    drive(1'b0, 16'h0, 4'h0, 64'h0, 1'b0);
    tick(); tick(); tick(); tick(); tick();
    chk("sat_cnt8", 64'(stall_cnt), 64'd8);
    chk("sat_cnt2", 64'(stall_cnt2), 64'd3);
    chk("sat_instr2", 64'(out_instr2), 64'h7001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
